// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file, two prioritised write ports, sequenced bulk clear
// Optional same-cycle write forwarding on the read ports: define REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [READ_PORTS*ADDR_W-1:0] rd_addr,
  output logic [READ_PORTS*DATA_W-1:0] rd_data,
  input  logic                         wr_en_a,
  input  logic [ADDR_W-1:0]            wr_addr_a,
  input  logic [DATA_W-1:0]            wr_data_a,
  input  logic                         wr_en_b,
  input  logic [ADDR_W-1:0]            wr_addr_b,
  input  logic [DATA_W-1:0]            wr_data_b,
  input  logic                         clr_req,
  output logic                         clr_busy,
  output logic                         clr_done
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [ADDR_W-1:0] FIRST_IDX = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] clrIdx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wrOkA;
  logic              wrOkB;

  // Writes to the hardwired zero register are dropped at the source.
  assign wrOkA = wr_en_a && !((ZERO_REG != 0) && (wr_addr_a == '0));
  assign wrOkB = wr_en_b && !((ZERO_REG != 0) && (wr_addr_b == '0));

  assign clr_busy = (state == CLEAR);
  assign clr_done = (state == CLEAR) && (clrIdx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      clrIdx <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == IDLE) begin
      // B is assigned last so it wins an address collision with A.
      if (wrOkA) mem[wr_addr_a] <= wr_data_a;
      if (wrOkB) mem[wr_addr_b] <= wr_data_b;
      if (clr_req) begin
        state  <= CLEAR;
        clrIdx <= FIRST_IDX;
      end
    end else begin
      mem[clrIdx] <= '0;
      if (clrIdx == LAST_IDX) begin
        state <= IDLE;
      end else begin
        clrIdx <= clrIdx + 1'b1;
      end
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] q;

    assign addr = rd_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      q = mem[addr];
`ifdef REGFILE_BYPASS_EN
      // The clear engine owns the array while busy, so nothing is forwarded then.
      if (!clr_busy) begin
        if (wrOkB && (wr_addr_b == addr)) begin
          q = wr_data_b;
        end else if (wrOkA && (wr_addr_a == addr)) begin
          q = wr_data_a;
        end
      end
`endif
      if ((ZERO_REG != 0) && (addr == '0)) q = '0;
    end

    assign rd_data[p*DATA_W +: DATA_W] = q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp (ZERO_REG=1 main instance, ZERO_REG=0 companion)
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [63:0] rdData0;
  logic        wr_en_a, wr_en_b;
  logic [4:0]  wr_addr_a, wr_addr_b;
  logic [31:0] wr_data_a, wr_data_b;
  logic        clr_req;
  logic        clr_busy, clr_done;
  logic        clrBusy0, clrDone0;

  regfile_mp #(.ZERO_REG(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  regfile_mp #(.ZERO_REG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdData0),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .clr_req(clr_req), .clr_busy(clrBusy0), .clr_done(clrDone0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model [32];
  int          total = 0;
  int          bad   = 0;

  task automatic chkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input int addr);
    exp_t e;
    e.addr = 5'(addr);
    e.data = model[addr];
    sbq.push_back(e);
  endtask

  task automatic pushAll();
    for (int i = 0; i < 32; i++) pushExp(i);
  endtask

  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      @(negedge clk);
      rd_addr = {e.addr, e.addr};
      #1;
      chkVal($sformatf("rd0[%0d]", e.addr), {32'h0, rd_data[31:0]}, {32'h0, e.data});
      chkVal($sformatf("rd1[%0d]", e.addr), {32'h0, rd_data[63:32]}, {32'h0, e.data});
    end
  endtask

  task automatic doWrite(input logic ea, input int aa, input logic [31:0] da,
                         input logic eb, input int ab, input logic [31:0] db);
    @(negedge clk);
    wr_en_a = ea; wr_addr_a = 5'(aa); wr_data_a = da;
    wr_en_b = eb; wr_addr_b = 5'(ab); wr_data_b = db;
    @(negedge clk);
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
    if (ea && aa != 0) model[aa] = da;
    if (eb && ab != 0) model[ab] = db;
  endtask

  task automatic preloadAll();
    for (int i = 1; i < 32; i++) doWrite(1'b1, i, 32'hA500_0000 | 32'(i), 1'b0, 0, 32'h0);
  endtask

  // Pulses clr_req for one cycle and follows the clear, trying writes to
  // already-cleared registers 1 and 2 at busy cycles 3 and 20.
  task automatic runClear(input int abortAt, output int busyCnt, output int doneCnt,
                          output logic lastDone);
    int n;
    busyCnt = 0; doneCnt = 0; lastDone = 1'b0; n = 0;
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    while (clr_busy && n < 100) begin
      busyCnt++;
      n++;
      if (clr_done) doneCnt++;
      lastDone = clr_done;
      if (abortAt != 0 && busyCnt == abortAt) begin
        rst_n = 1'b0;
        #1;
        chkVal("abort_busy", {63'h0, clr_busy}, 64'h0);
        chkVal("abort_done", {63'h0, clr_done}, 64'h0);
        break;
      end
      wr_en_a = (busyCnt == 3 || busyCnt == 20); wr_addr_a = 5'd2; wr_data_a = 32'hBAD0_0002;
      wr_en_b = (busyCnt == 3 || busyCnt == 20); wr_addr_b = 5'd1; wr_data_b = 32'hBAD0_0001;
      @(negedge clk);
    end
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
    chkVal("clr_timeout", {63'h0, n < 100}, 64'h1);
  endtask

  int          busyCnt, doneCnt;
  logic        lastDone;
  logic [31:0] bypExp;

  initial begin
    rst_n = 1'b0; clr_req = 1'b0; rd_addr = {5'd3, 5'd5};
    wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
    wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    #2;
    chkVal("rst_rd", rd_data, 64'h0);
    chkVal("rst_rd_z0", rdData0, 64'h0);
    chkVal("rst_busy", {63'h0, clr_busy}, 64'h0);
    chkVal("rst_done", {63'h0, clr_done}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    doWrite(1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, 32'h0);
    pushExp(5);
    drain();

    doWrite(1'b1, 7, 32'h1111_1111, 1'b1, 7, 32'h2222_2222);
    pushExp(7);
    drain();

    doWrite(1'b0, 0, 32'h0, 1'b1, 0, 32'hFFFF_FFFF);
    pushExp(0);
    drain();
    chkVal("zreg_off_rd0", {32'h0, rdData0[31:0]}, 64'hFFFF_FFFF);

    preloadAll();
    pushAll();
    drain();

    runClear(0, busyCnt, doneCnt, lastDone);
    chkVal("clr_busy_len", 64'(busyCnt), 64'd31);
    chkVal("clr_done_cnt", 64'(doneCnt), 64'd1);
    chkVal("clr_done_last", {63'h0, lastDone}, 64'h1);
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    pushAll();
    drain();

    preloadAll();
    runClear(10, busyCnt, doneCnt, lastDone);
    chkVal("abort_len", 64'(busyCnt), 64'd10);
    chkVal("abort_no_done", 64'(doneCnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    pushAll();
    drain();

    runClear(0, busyCnt, doneCnt, lastDone);
    chkVal("reclr_busy_len", 64'(busyCnt), 64'd31);
    chkVal("reclr_done_cnt", 64'(doneCnt), 64'd1);

    doWrite(1'b1, 9, 32'h1234_5678, 1'b0, 0, 32'h0);
`ifdef REGFILE_BYPASS_EN
    bypExp = 32'hCAFE_0001;
`else
    bypExp = 32'h1234_5678;
`endif
    @(negedge clk);
    rd_addr = {5'd9, 5'd0};
    wr_en_a = 1'b1; wr_addr_a = 5'd9; wr_data_a = 32'hCAFE_0001;
    #1;
    chkVal("bypass_p1", {32'h0, rd_data[63:32]}, {32'h0, bypExp});
    chkVal("bypass_p0_zero", {32'h0, rd_data[31:0]}, 64'h0);
    @(negedge clk);
    wr_en_a = 1'b0;
    model[9] = 32'hCAFE_0001;
    pushExp(9);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
